// File: rtl/pipe_trace_unit_pkg.sv
// Shared definitions for the pipeline trace recorder: FSM states, halt
// cause codes and the bit layout of one trace entry.
package pipe_trace_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_STOP    = 2'd1;
  localparam logic [1:0] CAUSE_BRK     = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Only the low bits of the cycle counter are kept per entry.
  localparam int CYC_LO_W = 8;

  // Entry layout, MSB to LSB: {cycle_lo, v, s, retire, pc}.
  localparam int OFF_PC = 0;

  function automatic int off_ret(input int addr_w);
    return addr_w;
  endfunction

  function automatic int off_s(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int off_v(input int nstage, input int addr_w);
    return addr_w + 1 + nstage;
  endfunction

  function automatic int off_cyc(input int nstage, input int addr_w);
    return addr_w + 1 + 2 * nstage;
  endfunction

  function automatic int ent_w(input int nstage, input int addr_w);
    return CYC_LO_W + 2 * nstage + 1 + addr_w;
  endfunction

endpackage

// File: rtl/pipe_trace_unit_trace_ram.sv
// Trace buffer storage: one write port, one registered read port, no reset,
// so it maps onto distributed RAM.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int ENT_W = 41,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [ENT_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [ENT_W-1:0] rdata
);

  logic [ENT_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds when re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_unit.sv
// Per-cycle pipeline trace recorder: captures per-boundary valid/stall bits
// and the retiring address into a ring buffer while running, counts cycles,
// retirements and stalls, halts on stop/breakpoint/timeout and then serves
// indexed reads of the buffer, oldest entry first.
module pipe_trace_unit
  import pipe_trace_unit_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int CYC_W  = 32,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int ENT_W = ent_w(NSTAGE, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  input  logic [NSTAGE-1:0] v_i,
  input  logic [NSTAGE-1:0] s_i,
  input  logic              retire_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              brk_en_i,
  input  logic [ADDR_W-1:0] brk_addr_i,
  input  logic [CYC_W-1:0]  max_cyc_i,
  input  logic              rd_req_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ENT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_err_o,
  output logic [1:0]        state_o,
  output logic [1:0]        cause_o,
  output logic [IDX_W:0]    count_o,
  output logic [CYC_W-1:0]  cycle_o,
  output logic [CYC_W-1:0]  retired_o,
  output logic [CYC_W-1:0]  stall_o
);

  localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

  state_t           state, state_nxt;
  logic             is_idle, is_run, is_halt;
  logic             hit_stop, hit_brk, hit_tmo, halt_any;
  logic [1:0]       cause_nxt;
  logic [CYC_W-1:0] cycle_q, retired_q, stall_q;
  logic [IDX_W-1:0] wptr, oldest, raddr;
  logic [IDX_W:0]   count_q;
  logic [1:0]       cause_q;
  logic [ADDR_W-1:0] pc_rec;
  logic [ENT_W-1:0] wdata, ram_q;
  logic             idx_err, rd_go;
  logic             rd_vld_p1, rd_err_p1, rd_zero_p1;

  // Halt conditions, evaluated on this cycle's inputs
  assign hit_stop = stop_i;
  assign hit_brk  = brk_en_i && retire_i && (pc_i == brk_addr_i);
  assign hit_tmo  = (max_cyc_i != '0) && (cycle_q == max_cyc_i - CYC_W'(1));
  assign halt_any = hit_stop || hit_brk || hit_tmo;

  // Cause priority: stop over breakpoint over timeout
  always_comb begin
    cause_nxt = CAUSE_NONE;
    if (hit_stop)     cause_nxt = CAUSE_STOP;
    else if (hit_brk) cause_nxt = CAUSE_BRK;
    else if (hit_tmo) cause_nxt = CAUSE_TIMEOUT;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i)  state_nxt = ST_RUN;
      ST_RUN:  if (halt_any) state_nxt = ST_HALT;
      ST_HALT: if (clear_i)  state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    is_idle = (state == ST_IDLE);
    is_run  = (state == ST_RUN);
    is_halt = (state == ST_HALT);
    state_o = state;
  end

  // Counters, write pointer, fill level and halt cause
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= '0;
      retired_q <= '0;
      stall_q   <= '0;
      wptr      <= '0;
      count_q   <= '0;
      cause_q   <= CAUSE_NONE;
    end else if (is_idle && start_i) begin
      cycle_q   <= '0;
      retired_q <= '0;
      stall_q   <= '0;
      wptr      <= '0;
      count_q   <= '0;
      cause_q   <= CAUSE_NONE;
    end else if (is_run) begin
      cycle_q <= cycle_q + CYC_W'(1);
      if (retire_i) retired_q <= retired_q + CYC_W'(1);
      if (|s_i)     stall_q   <= stall_q + CYC_W'(1);
      wptr <= wptr + IDX_W'(1);
      if (count_q != FULL) count_q <= count_q + (IDX_W + 1)'(1);
      cause_q <= cause_nxt;
    end else if (is_halt && clear_i) begin
      count_q <= '0;
      cause_q <= CAUSE_NONE;
    end
  end

  // Entry captured this cycle; the cycle field is the pre-increment count
  assign pc_rec = retire_i ? pc_i : '0;
  assign wdata  = {cycle_q[CYC_LO_W-1:0], v_i, s_i, retire_i, pc_rec};

  // Read addressing: index 0 is the oldest surviving entry
  assign oldest  = (count_q == FULL) ? wptr : '0;
  assign raddr   = oldest + rd_idx_i;
  assign idx_err = ({1'b0, rd_idx_i} >= count_q);
  assign rd_go   = is_halt && rd_req_i && !clear_i;

  trace_ram #(
    .DEPTH (DEPTH),
    .ENT_W (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (is_run),
    .waddr (wptr),
    .wdata (wdata),
    .re    (rd_go && !idx_err),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Read response stage; rd_zero forces rd_data to 0 after reset or a bad index
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_vld_p1  <= 1'b0;
      rd_err_p1  <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      rd_vld_p1 <= rd_go;
      rd_err_p1 <= rd_go && idx_err;
      if (rd_go) rd_zero_p1 <= idx_err;
    end
  end

  assign rd_data_o  = rd_zero_p1 ? '0 : ram_q;
  assign rd_valid_o = rd_vld_p1;
  assign rd_err_o   = rd_err_p1;
  assign cause_o    = cause_q;
  assign count_o    = count_q;
  assign cycle_o    = cycle_q;
  assign retired_o  = retired_q;
  assign stall_o    = stall_q;

endmodule

// File: tb/tb_pipe_trace_unit.sv
// Directed testbench for pipe_trace_unit.
module tb_pipe_trace_unit;
  import pipe_trace_unit_pkg::*;

  localparam int NSTAGE = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;
  localparam int CYC_W  = 32;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int EW     = ent_w(NSTAGE, ADDR_W);
  localparam int O_RET  = off_ret(ADDR_W);
  localparam int O_S    = off_s(ADDR_W);
  localparam int O_V    = off_v(NSTAGE, ADDR_W);
  localparam int O_CYC  = off_cyc(NSTAGE, ADDR_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, stop_i, clear_i;
  logic [NSTAGE-1:0] v_i, s_i;
  logic              retire_i;
  logic [ADDR_W-1:0] pc_i, brk_addr_i;
  logic              brk_en_i;
  logic [CYC_W-1:0]  max_cyc_i;
  logic              rd_req_i;
  logic [IDX_W-1:0]  rd_idx_i;
  logic [EW-1:0]     rd_data_o;
  logic              rd_valid_o, rd_err_o;
  logic [1:0]        state_o, cause_o;
  logic [IDX_W:0]    count_o;
  logic [CYC_W-1:0]  cycle_o, retired_o, stall_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_trace_unit #(
    .NSTAGE (NSTAGE),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CYC_W  (CYC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .v_i        (v_i),
    .s_i        (s_i),
    .retire_i   (retire_i),
    .pc_i       (pc_i),
    .brk_en_i   (brk_en_i),
    .brk_addr_i (brk_addr_i),
    .max_cyc_i  (max_cyc_i),
    .rd_req_i   (rd_req_i),
    .rd_idx_i   (rd_idx_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .rd_err_o   (rd_err_o),
    .state_o    (state_o),
    .cause_o    (cause_o),
    .count_o    (count_o),
    .cycle_o    (cycle_o),
    .retired_o  (retired_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] idx);
    rd_req_i = 1'b1;
    rd_idx_i = idx;
    tick();
    rd_req_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_cmp++;
    if ({state_o, cause_o, count_o, rd_valid_o, rd_err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: got state=%0d cause=%0d count=%0d vld=%b err=%b, expected all 0",
               state_o, cause_o, count_o, rd_valid_o, rd_err_o);
    end
    n_cmp++;
    if ({cycle_o, retired_o, stall_o, rd_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got cyc=%0d ret=%0d stall=%0d data=%h, expected all 0",
               cycle_o, retired_o, stall_o, rd_data_o);
    end
  endtask

  task automatic test_timeout();
    max_cyc_i = 18;
    pc_i = 16'hABCD;
    start_run();
    n_cmp++;
    if (state_o !== 2'd1 || cycle_o !== 0) begin
      n_fail++;
      $display("FAIL tmo_start: got state=%0d cyc=%0d, expected 1/0", state_o, cycle_o);
    end
    repeat (17) tick();
    n_cmp++;
    if (state_o !== 2'd1 || cycle_o !== 17) begin
      n_fail++;
      $display("FAIL tmo_before: got state=%0d cyc=%0d, expected 1/17", state_o, cycle_o);
    end
    tick();
    n_cmp++;
    if (state_o !== 2'd2 || cause_o !== 2'd3 || cycle_o !== 18 || count_o !== 16) begin
      n_fail++;
      $display("FAIL tmo_halt: got state=%0d cause=%0d cyc=%0d count=%0d, expected 2/3/18/16",
               state_o, cause_o, cycle_o, count_o);
    end
    do_read(0);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b0 || rd_data_o[O_CYC +: 8] !== 8'd2 ||
        rd_data_o[ADDR_W-1:0] !== '0) begin
      n_fail++;
      $display("FAIL tmo_rd0: got vld=%b err=%b cyc=%0d pc=%h, expected 1/0/2/0000",
               rd_valid_o, rd_err_o, rd_data_o[O_CYC +: 8], rd_data_o[ADDR_W-1:0]);
    end
    do_read(15);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || rd_data_o[O_CYC +: 8] !== 8'd17) begin
      n_fail++;
      $display("FAIL tmo_rd15: got vld=%b cyc=%0d, expected 1/17", rd_valid_o, rd_data_o[O_CYC +: 8]);
    end
    do_clear();
    n_cmp++;
    if (state_o !== 2'd0 || count_o !== 0 || cause_o !== 2'd0 || cycle_o !== 18) begin
      n_fail++;
      $display("FAIL tmo_clear: got state=%0d count=%0d cause=%0d cyc=%0d, expected 0/0/0/18",
               state_o, count_o, cause_o, cycle_o);
    end
    max_cyc_i = 0;
    pc_i = '0;
  endtask

  task automatic test_breakpoint();
    brk_en_i = 1'b1;
    brk_addr_i = 16'h0006;
    start_run();
    for (int i = 0; i < 4; i++) begin
      retire_i = 1'b1;
      pc_i = ADDR_W'(2 * i);
      tick();
      if (i == 2) begin
        n_cmp++;
        if (state_o !== 2'd1) begin
          n_fail++;
          $display("FAIL brk_early: got state=%0d, expected 1", state_o);
        end
      end
    end
    retire_i = 1'b0;
    pc_i = '0;
    n_cmp++;
    if (state_o !== 2'd2 || cause_o !== 2'd2 || retired_o !== 4 || count_o !== 4 || cycle_o !== 4) begin
      n_fail++;
      $display("FAIL brk_halt: got state=%0d cause=%0d ret=%0d count=%0d cyc=%0d, expected 2/2/4/4/4",
               state_o, cause_o, retired_o, count_o, cycle_o);
    end
  endtask

  task automatic test_read();
    logic [EW-1:0] held;
    do_read(3);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b0 || rd_data_o[ADDR_W-1:0] !== 16'h0006 ||
        rd_data_o[O_RET] !== 1'b1 || rd_data_o[O_CYC +: 8] !== 8'd3) begin
      n_fail++;
      $display("FAIL rd_idx3: got vld=%b err=%b pc=%h ret=%b cyc=%0d, expected 1/0/0006/1/3",
               rd_valid_o, rd_err_o, rd_data_o[ADDR_W-1:0], rd_data_o[O_RET], rd_data_o[O_CYC +: 8]);
    end
    held = rd_data_o;
    tick();
    n_cmp++;
    if (rd_valid_o !== 1'b0 || rd_err_o !== 1'b0 || rd_data_o !== held) begin
      n_fail++;
      $display("FAIL rd_idle: got vld=%b err=%b data=%h, expected 0/0/%h", rd_valid_o, rd_err_o, rd_data_o, held);
    end
    do_read(9);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b1 || rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL rd_idx9: got vld=%b err=%b data=%h, expected 1/1/0", rd_valid_o, rd_err_o, rd_data_o);
    end
    clear_i = 1'b1;
    rd_req_i = 1'b1;
    rd_idx_i = '0;
    tick();
    clear_i = 1'b0;
    rd_req_i = 1'b0;
    n_cmp++;
    if (rd_valid_o !== 1'b0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL rd_clear_prio: got vld=%b state=%0d, expected 0/0", rd_valid_o, state_o);
    end
    brk_en_i = 1'b0;
  endtask

  task automatic test_stop_brk();
    brk_en_i = 1'b1;
    brk_addr_i = 16'h0010;
    start_run();
    tick();
    stop_i = 1'b1;
    retire_i = 1'b1;
    pc_i = 16'h0010;
    tick();
    stop_i = 1'b0;
    retire_i = 1'b0;
    pc_i = '0;
    n_cmp++;
    if (state_o !== 2'd2 || cause_o !== 2'd1 || count_o !== 2 || retired_o !== 1) begin
      n_fail++;
      $display("FAIL stopbrk_halt: got state=%0d cause=%0d count=%0d ret=%0d, expected 2/1/2/1",
               state_o, cause_o, count_o, retired_o);
    end
    do_read(1);
    n_cmp++;
    if (rd_data_o[ADDR_W-1:0] !== 16'h0010 || rd_data_o[O_RET] !== 1'b1 || rd_data_o[O_CYC +: 8] !== 8'd1) begin
      n_fail++;
      $display("FAIL stopbrk_entry: got pc=%h ret=%b cyc=%0d, expected 0010/1/1",
               rd_data_o[ADDR_W-1:0], rd_data_o[O_RET], rd_data_o[O_CYC +: 8]);
    end
    do_clear();
    brk_en_i = 1'b0;
  endtask

  task automatic test_stall();
    logic [NSTAGE-1:0] exp_s;
    start_run();
    for (int i = 0; i < 10; i++) begin
      v_i = i[NSTAGE-1:0];
      s_i = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      tick();
    end
    v_i = '0;
    s_i = '0;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    n_cmp++;
    if (state_o !== 2'd2 || cause_o !== 2'd1 || stall_o !== 5 || cycle_o !== 11 || count_o !== 11) begin
      n_fail++;
      $display("FAIL stall_halt: got state=%0d cause=%0d stall=%0d cyc=%0d count=%0d, expected 2/1/5/11/11",
               state_o, cause_o, stall_o, cycle_o, count_o);
    end
    for (int i = 0; i < 10; i++) begin
      exp_s = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      do_read(i[IDX_W-1:0]);
      n_cmp++;
      if (rd_data_o[O_S +: NSTAGE] !== exp_s || rd_data_o[O_V +: NSTAGE] !== i[NSTAGE-1:0]) begin
        n_fail++;
        $display("FAIL stall_entry%0d: got s=%b v=%b, expected s=%b v=%b",
                 i, rd_data_o[O_S +: NSTAGE], rd_data_o[O_V +: NSTAGE], exp_s, i[NSTAGE-1:0]);
      end
    end
    do_clear();
  endtask

  task automatic test_reset_mid_run();
    start_run();
    retire_i = 1'b1;
    s_i = 4'b0001;
    pc_i = 16'h0022;
    repeat (7) tick();
    n_cmp++;
    if (state_o !== 2'd1 || cycle_o !== 7) begin
      n_fail++;
      $display("FAIL rstrun_pre: got state=%0d cyc=%0d, expected 1/7", state_o, cycle_o);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    retire_i = 1'b0;
    s_i = '0;
    pc_i = '0;
    n_cmp++;
    if ({state_o, cause_o, count_o, rd_valid_o, rd_err_o} !== '0 ||
        {cycle_o, retired_o, stall_o, rd_data_o} !== '0) begin
      n_fail++;
      $display("FAIL rstrun_outputs: got state=%0d cyc=%0d ret=%0d stall=%0d count=%0d data=%h, expected all 0",
               state_o, cycle_o, retired_o, stall_o, count_o, rd_data_o);
    end
    start_run();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    do_read(0);
    n_cmp++;
    if (rd_valid_o !== 1'b1 || count_o !== 1 || rd_data_o[O_CYC +: 8] !== 8'd0) begin
      n_fail++;
      $display("FAIL rstrun_restart: got vld=%b count=%0d cyc=%0d, expected 1/1/0",
               rd_valid_o, count_o, rd_data_o[O_CYC +: 8]);
    end
    do_clear();
  endtask

  initial begin
    rst = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    clear_i = 1'b0;
    v_i = '0;
    s_i = '0;
    retire_i = 1'b0;
    pc_i = '0;
    brk_en_i = 1'b0;
    brk_addr_i = '0;
    max_cyc_i = '0;
    rd_req_i = 1'b0;
    rd_idx_i = '0;
    test_reset();
    test_timeout();
    test_breakpoint();
    test_read();
    test_stop_brk();
    test_stall();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
